// File: rtl/riscv_pkg.sv
// Shared RISC-V opcode constants and immediate-format encodings,
// used by the IF/ID stage and by the immediate extender.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_J    = 3'd3,
        IMM_U    = 3'd4,
        IMM_NONE = 3'd7
    } imm_sel_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        imm_sel_e    imm;
        logic        illegal;
    } entry_t;

endpackage

// File: rtl/imm_sel_decode.sv
// Combinational opcode-to-immediate-format decode for the IF/ID input path.
module imm_sel_decode
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output imm_sel_e    imm_ctrl,
    output logic        illegal
);

    always_comb begin
        imm_ctrl = IMM_NONE;
        illegal  = 1'b0;
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (instr[6:0])
                OP_LOAD, OP_IMM, OP_JALR: imm_ctrl = IMM_I;
                OP_STORE:                 imm_ctrl = IMM_S;
                OP_BRANCH:                imm_ctrl = IMM_B;
                OP_JAL:                   imm_ctrl = IMM_J;
                OP_LUI, OP_AUIPC:         imm_ctrl = IMM_U;
                OP_REG:                   imm_ctrl = IMM_NONE;
                default:                  illegal  = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/if_id_decode.sv
// IF/ID pipeline register with captured immediate-format decode.
// Define IF_ID_SKID_EN for a registered-ready main+skid buffer; default is a single entry.
module if_id_decode
    import riscv_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [2:0]  out_imm_ctrl,
    output logic        out_illegal
);

    imm_sel_e dec_imm;
    logic     dec_ill;
    entry_t   in_entry;

    imm_sel_decode u_dec (
        .instr    (in_instr),
        .imm_ctrl (dec_imm),
        .illegal  (dec_ill)
    );

    assign in_entry = '{instr: in_instr, pc: in_pc, imm: dec_imm, illegal: dec_ill};

    entry_t main_q, main_d;
    logic   main_v_q, main_v_d;
    logic   in_fire, out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

`ifdef IF_ID_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_v_q, skid_v_d;
    logic   ready_q;

    assign in_ready = ready_q;

    // ready_q mirrors !skid_v_q, so a skid refill never coincides with a capture
    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (out_fire) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end else begin
                main_v_d = in_fire;
                if (in_fire) main_d = in_entry;
            end
        end else if (in_fire) begin
            if (main_v_q) begin
                skid_d   = in_entry;
                skid_v_d = 1'b1;
            end else begin
                main_d   = in_entry;
                main_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            ready_q  <= !skid_v_d;
        end
    end

    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end
`else
    assign in_ready = !main_v_q || out_ready;

    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        if (in_fire) begin
            main_d   = in_entry;
            main_v_d = 1'b1;
        end else if (out_fire) begin
            main_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) main_v_q <= 1'b0;
        else                 main_v_q <= main_v_d;
    end

    always_ff @(posedge clk) begin
        main_q <= main_d;
    end
`endif

    // Payload flops are not reset; the empty-state values are muxed in here.
    assign out_valid    = main_v_q;
    assign out_instr    = main_v_q ? main_q.instr   : NOP_INSTR;
    assign out_pc       = main_v_q ? main_q.pc      : '0;
    assign out_imm_ctrl = main_v_q ? main_q.imm     : IMM_I;
    assign out_illegal  = main_v_q ? main_q.illegal : 1'b0;

endmodule

// File: tb/tb_if_id_decode.sv
// Scoreboard bench for if_id_decode: driver pushes expected entries on accept,
// a negedge monitor compares whatever the DUT presents against the queue head.
module tb_if_id_decode;

`ifdef IF_ID_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc, out_instr, out_pc;
    logic [2:0]  out_imm_ctrl;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  imm;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    if_id_decode #(.NOP_INSTR(32'h0000_0013)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_imm_ctrl (out_imm_ctrl),
        .out_illegal  (out_illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; rdy/ov are sampled at the negedge.
    task automatic step(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [2:0] imm, input bit ill, input bit ordy,
                        input bit fl, input bit rn, output bit rdy, output bit ov);
        bit acc;
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        rst_n     = rn;
        @(negedge clk);
        rdy = in_ready;
        ov  = out_valid;
        acc = v && in_ready && !fl && rn;
        @(posedge clk);
        #1;
        if (!fl && rn) begin
            if (acc) q.push_back('{instr, pc, imm, ill});
        end else begin
            q.delete();
        end
    endtask

    task automatic idle(input bit ordy, output bit rdy, output bit ov);
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, ordy, 1'b0, 1'b1, rdy, ov);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got instr %h expected no output at %0t", out_instr, $time);
                end else begin
                    chk("out_instr", out_instr, q[0].instr);
                    chk("out_pc", out_pc, q[0].pc);
                    chk("out_imm_ctrl", {29'd0, out_imm_ctrl}, {29'd0, q[0].imm});
                    chk("out_illegal", {31'd0, out_illegal}, {31'd0, q[0].ill});
                    if (out_ready === 1'b1) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end else begin
                chk("empty_valid", {31'd0, out_valid}, 32'd0);
                chk("empty_instr", out_instr, 32'h0000_0013);
                chk("empty_pc", out_pc, 32'd0);
                chk("empty_imm", {29'd0, out_imm_ctrl}, 32'd0);
                chk("empty_ill", {31'd0, out_illegal}, 32'd0);
            end
        end
    end

    initial begin
        bit r, o;
        logic [31:0] b2b_i [4] = '{32'h00112023, 32'h00208463, 32'h008000EF, 32'h123450B7};
        logic [2:0]  b2b_m [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [31:0] mix_i [6] = '{32'h002081B3, 32'h0000A103, 32'h00000197,
                                   32'h000080E7, 32'h0000007F, 32'h00000010};
        logic [2:0]  mix_m [6] = '{3'd7, 3'd0, 3'd4, 3'd0, 3'd7, 3'd7};
        bit          mix_x [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] st_i  [3] = '{32'h00112023, 32'h00208463, 32'h008000EF};
        logic [2:0]  st_m  [3] = '{3'd1, 3'd2, 3'd3};

        in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0; flush = 0; rst_n = 0;
        step(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, r, o);
        step(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, r, o);
        mon_en = 1'b1;

        // reset state and first-cycle ready
        idle(1'b1, r, o);
        chk("rst_in_ready", {31'd0, r}, 32'd1);
        chk("rst_out_valid", {31'd0, o}, 32'd0);

        // single addi: one-cycle latency
        step(1'b1, 32'h00A00093, 32'h100, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, r, o);
        chk("addi_in_ready", {31'd0, r}, 32'd1);
        idle(1'b1, r, o);
        chk("addi_latency_valid", {31'd0, o}, 32'd1);
        idle(1'b1, r, o);

        // back-to-back sw/beq/jal/lui without bubbles
        for (int unsigned i = 0; i < 4; i++) begin
            step(1'b1, b2b_i[i], 32'h200 + 4 * i, b2b_m[i], 1'b0, 1'b1, 1'b0, 1'b1, r, o);
            chk("b2b_in_ready", {31'd0, r}, 32'd1);
            if (i > 0) chk("b2b_no_bubble", {31'd0, o}, 32'd1);
        end
        idle(1'b1, r, o);
        chk("b2b_last_valid", {31'd0, o}, 32'd1);
        idle(1'b1, r, o);

        // other formats and illegal encodings, streaming
        for (int unsigned i = 0; i < 6; i++)
            step(1'b1, mix_i[i], 32'h300 + 4 * i, mix_m[i], mix_x[i], 1'b1, 1'b0, 1'b1, r, o);
        idle(1'b1, r, o);
        idle(1'b1, r, o);

        // stall for three cycles with input offered every cycle
        for (int unsigned i = 0; i < 3; i++) begin
            step(1'b1, st_i[i], 32'h400 + 4 * i, st_m[i], 1'b0, 1'b0, 1'b0, 1'b1, r, o);
            if (i == 0)      chk("stall_rdy0", {31'd0, r}, 32'd1);
            else if (i == 1) chk("stall_rdy1", {31'd0, r}, {31'd0, SKID});
            else             chk("stall_rdy2", {31'd0, r}, 32'd0);
        end
        for (int unsigned i = 0; i < 3; i++) idle(1'b1, r, o);

        // flush while full with input offered
        step(1'b1, 32'h00112023, 32'h500, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, r, o);
        step(1'b1, 32'h00208463, 32'h504, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, r, o);
        step(1'b1, 32'h123450B7, 32'h508, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, r, o);
        idle(1'b1, r, o);
        chk("flush_out_valid", {31'd0, o}, 32'd0);
        chk("flush_in_ready", {31'd0, r}, 32'd1);
        idle(1'b1, r, o);
        idle(1'b1, r, o);

        // reset mid-stream with entries full and an accept in flight
        step(1'b1, 32'h008000EF, 32'h600, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, r, o);
        step(1'b1, 32'h0000A103, 32'h604, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, r, o);
        step(1'b1, 32'h00000197, 32'h608, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, r, o);
        idle(1'b1, r, o);
        chk("reset_out_valid", {31'd0, o}, 32'd0);
        chk("reset_in_ready", {31'd0, r}, 32'd1);
        idle(1'b1, r, o);

        // normal operation resumes after reset
        step(1'b1, 32'h00A00093, 32'h700, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, r, o);
        for (int unsigned i = 0; i < 3; i++) idle(1'b1, r, o);

        chk("queue_drained", q.size(), 32'd0);
        chk("outputs_seen", n_out, SKID ? 32'd14 : 32'd13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_decode.md
IF_ID_DECODE -- requirements
Module: if_id_decode

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h0000_0013, the instruction word presented while the stage is empty.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, reset (synchronous, active-low).
REQ-004 SHALL have port flush, input, 1, synchronous discard of all held instructions.
REQ-005 SHALL have port in_valid, input, 1, fetch offers in_instr/in_pc.
REQ-006 SHALL have port in_ready, output, 1, stage accepts this cycle.
REQ-007 SHALL have port in_instr, input, 32, fetched instruction word.
REQ-008 SHALL have port in_pc, input, 32, PC of in_instr.
REQ-009 SHALL have port out_valid, output, 1, decode entry presented.
REQ-010 SHALL have port out_ready, input, 1, extender/decode consumer accepts.
REQ-011 SHALL have port out_instr, output, 32, instruction word driven to the extender Instr input.
REQ-012 SHALL have port out_pc, output, 32, PC of out_instr.
REQ-013 SHALL have port out_imm_ctrl, output, 3, immediate format for the extender: I=0, S=1, B=2, J=3, U=4, NONE=7.
REQ-014 SHALL have port out_illegal, output, 1, out_instr has an unsupported opcode.

Function
REQ-015 SHALL transfer on the input side when in_valid && in_ready and on the output side when out_valid && out_ready.
REQ-016 SHALL present an accepted instruction on out_* exactly one cycle after acceptance when the stage was empty.
REQ-017 SHALL decode out_imm_ctrl from instr[6:0] at capture time and hold it in a flop: 0000011/0010011/1100111 -> I; 0100011 -> S; 1100011 -> B; 1101111 -> J; 0110111/0010111 -> U; 0110011 -> NONE.
REQ-018 SHALL set out_illegal=1 and out_imm_ctrl=NONE for any other opcode or when instr[1:0] != 2'b11.
REQ-019 SHALL keep out_instr, out_pc, out_imm_ctrl and out_illegal stable while out_valid && !out_ready.
REQ-020 SHALL, when empty, drive out_valid=0, out_instr=NOP_INSTR, out_pc=0, out_imm_ctrl=I, out_illegal=0.
REQ-021 SHALL preserve instruction order; no accepted instruction is dropped or duplicated except by flush.
REQ-022 SHALL, on flush, empty every entry at the next edge and discard any input handshake in the same cycle; flush has priority over capture.
REQ-023 SHALL handle simultaneous input and output transfer in one cycle without a bubble.

Reset
REQ-024 SHALL, on a clk edge with rst_n=0, empty all entries and drive outputs per REQ-020, with in_ready=1 in the first cycle after reset release.
REQ-025 SHALL let reset abort any in-flight instruction, including one being accepted in the same cycle.

Configuration
REQ-026 SHALL, with IF_ID_SKID_EN defined, implement a main entry plus one skid entry, with in_ready a flop equal to "skid entry empty", sustaining one instruction per cycle.
REQ-027 SHALL, with IF_ID_SKID_EN defined, drop in_ready to 0 when both entries are full and refill the main entry from the skid entry on out_ready.
REQ-028 SHALL, without IF_ID_SKID_EN, implement a single entry with combinational in_ready = !out_valid || out_ready.

Structure
REQ-029 SHALL take the opcode constants and the IMM_I/IMM_S/IMM_B/IMM_J/IMM_U/IMM_NONE encodings from shared package riscv_pkg, which the extender uses as well.
REQ-030 SHALL place the opcode-to-format decode in one combinational sub-module, imm_sel_decode, instantiated on the input path.

Verification
REQ-031 SHALL pass this check: after reset, in_instr=32'h00A00093 (addi), pc=0x100, out_ready=1 -> next cycle out_valid=1, out_imm_ctrl=0, out_illegal=0, out_pc=0x100.
REQ-032 SHALL pass this check: back-to-back sw 32'h00112023, beq 32'h00208463, jal 32'h008000EF, lui 32'h123450B7 with out_ready=1 -> imm_ctrl 1, 2, 3, 4 on consecutive cycles, no bubble.
REQ-033 SHALL pass this check: out_ready=0 for 3 cycles with in_valid=1 -> outputs frozen; in_ready falls after 2 accepts (SKID) or 1 accept (no SKID); on release, order is preserved.
REQ-034 SHALL pass this check: flush asserted while full and in_valid=1 -> next cycle out_valid=0, out_instr=32'h00000013, and the flushed-cycle input is never output.
REQ-035 SHALL pass this check: in_instr=32'h0000007F and 32'h00000013 with bits[1:0] forced to 2'b00 -> out_illegal=1, out_imm_ctrl=7.
REQ-036 SHALL pass this check: rst_n=0 for one cycle mid-stream with both entries full -> empty outputs per REQ-020 and in_ready=1 after release.
